// File: rtl/alu_div8_seq_if.sv
// Request/response bundle between the control unit (master) and the
// sequential divider (slave).
interface alu_div8_seq_if;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/alu_div8_seq.sv
// 8-bit unsigned restoring divider that borrows the ALU's adder for its
// trial subtractions, one quotient bit per cycle.
module alu_div8_seq (
    input  logic             clk,
    input  logic             rst_n,
    alu_div8_seq_if.slave    bus,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic             alu_cin,
    input  logic [7:0]       alu_sum,
    input  logic             alu_cout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] dvd_q, dvd_d;
    logic [7:0] dvs_q, dvs_d;
    logic [7:0] rem_w_q, rem_w_d;
    logic [7:0] quo_w_q, quo_w_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] quo_q, quo_d;
    logic [7:0] rem_q, rem_d;
    logic       dbz_q, dbz_d;
    logic [7:0] shifted_s;
    logic [7:0] quo_next_s;

    // Next-state, iteration datapath and adder drive.
    always_comb begin
        shifted_s  = {rem_w_q[6:0], dvd_q[cnt_q]};
        quo_next_s = quo_w_q;
        quo_next_s[cnt_q] = alu_cout;

        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_w_d = rem_w_q;
        quo_w_d = quo_w_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        alu_a   = 8'h00;
        alu_b   = 8'h00;
        alu_cin = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    dvd_d = bus.dividend;
                    dvs_d = bus.divisor;
                    if (bus.divisor == 8'h00) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        quo_d   = 8'hFF;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        busy_d  = 1'b1;
                        cnt_d   = 3'd7;
                        rem_w_d = 8'h00;
                        quo_w_d = 8'h00;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Subtract via a + ~b + 1; carry out means no borrow.
                alu_a   = shifted_s;
                alu_b   = ~dvs_q;
                alu_cin = 1'b1;
                rem_w_d = alu_cout ? alu_sum : shifted_s;
                quo_w_d = quo_next_s;
                if (cnt_q == 3'd0) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    quo_d   = quo_next_s;
                    rem_d   = rem_w_d;
                    dbz_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            dvd_q   <= 8'h00;
            dvs_q   <= 8'h00;
            rem_w_q <= 8'h00;
            quo_w_q <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= 8'h00;
            rem_q   <= 8'h00;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_w_q <= rem_w_d;
            quo_w_q <= quo_w_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_div8_seq.sv
// Scoreboard bench for alu_div8_seq with a behavioural adder closing the
// alu_* loop; a negedge monitor checks results, latency and adder drive.
module tb_alu_div8_seq;

    logic       clk;
    logic       rst_n;
    logic [7:0] alu_a, alu_b, alu_sum;
    logic       alu_cin, alu_cout;

    alu_div8_seq_if bus ();

    alu_div8_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_cin  (alu_cin),
        .alu_sum  (alu_sum),
        .alu_cout (alu_cout)
    );

    assign {alu_cout, alu_sum} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        int         acc;
        int         lat;
        int         nbusy;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         busy_cnt = 0;
    logic [7:0] exp_nb = 8'h00;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: adder-drive checks every cycle, scoreboard pop on done.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.busy) begin
                chk("alu_b_run", alu_b, exp_nb);
                chk("alu_cin_run", alu_cin, 1);
                busy_cnt = busy_cnt + 1;
            end else begin
                chk("alu_idle", {alu_a, alu_b, alu_cin}, 0);
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", bus.quotient, e.q);
                    chk("remainder", bus.remainder, e.r);
                    chk("div_by_zero", bus.div_by_zero, e.z);
                    chk("latency", cyc - e.acc + 1, e.lat);
                    chk("busy_cycles", busy_cnt, e.nbusy);
                    chk("busy_at_done", bus.busy, 0);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic issue(input logic [7:0] n, input logic [7:0] d,
                         input logic [7:0] q, input logic [7:0] r, input logic z);
        exp_t e;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = n;
        bus.divisor  = d;
        exp_nb       = ~d;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        e.q     = q;
        e.r     = r;
        e.z     = z;
        e.acc   = cyc;
        e.lat   = z ? 1 : 9;
        e.nbusy = z ? 0 : 8;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            #1;
            n = n + 1;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", n, 0);
            sb.delete();
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = 8'h00;
        bus.divisor  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_status", {bus.busy, bus.done, bus.div_by_zero}, 0);
        chk("reset_results", {bus.quotient, bus.remainder}, 0);
        chk("reset_alu", {alu_a, alu_b, alu_cin}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(8'd200, 8'd7,   8'd28,  8'd4,  1'b0); wait_idle();
        issue(8'd255, 8'd1,   8'd255, 8'd0,  1'b0); wait_idle();
        issue(8'd255, 8'd255, 8'd1,   8'd0,  1'b0); wait_idle();
        issue(8'd5,   8'd200, 8'd0,   8'd5,  1'b0); wait_idle();
        issue(8'd10,  8'd0,   8'hFF,  8'd10, 1'b1); wait_idle();

        // Start pulses and input changes while running must be ignored.
        issue(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
        repeat (2) @(negedge clk);
        chk("held_quotient", bus.quotient, 8'hFF);
        chk("held_remainder", bus.remainder, 8'd10);
        chk("held_dbz", bus.div_by_zero, 1);
        bus.start    = 1'b1;
        bus.dividend = 8'd1;
        bus.divisor  = 8'd1;
        @(negedge clk);
        bus.dividend = 8'd3;
        bus.divisor  = 8'd0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        // Reset in the 4th RUN cycle aborts with no done pulse.
        issue(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_status", {bus.busy, bus.done, bus.div_by_zero}, 0);
        chk("abort_results", {bus.quotient, bus.remainder}, 0);
        chk("abort_alu", {alu_a, alu_b, alu_cin}, 0);
        sb.delete();
        busy_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        issue(8'd100, 8'd9, 8'd11, 8'd1, 1'b0); wait_idle();
        repeat (3) @(negedge clk);
        chk("final_hold_quotient", bus.quotient, 8'd11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
